// File: rtl/md_iter_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// The result is computed at issue and held in a pending register until the busy countdown expires.
module md_iter_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic             exc_int,
    output logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MUL_N = CW'(MUL_CYCLES);
    localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE   = CW'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;

    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic               busy_q, busy_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               is_mul_s, is_div_s, is_mt_s;
    logic               start_s, mt_ok_s;
    logic               mul_signed_s;
    logic [2*WIDTH-1:0] mul_a_s, mul_b_s, prod_s;
    logic               a_neg_s, b_neg_s;
    logic [WIDTH-1:0]   abs_a_s, abs_b_s, uq_s, ur_s, quot_s, rem_s;
    logic [WIDTH-1:0]   res_hi_s, res_lo_s;

    // Opcode decode; codes 0 and 9-15 fall through as no-ops
    always_comb begin
        is_mul_s = 1'b0;
        is_div_s = 1'b0;
        is_mt_s  = 1'b0;
        case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: is_mul_s = 1'b1;
            OP_DIV, OP_DIVU:                     is_div_s = 1'b1;
            OP_MTHI, OP_MTLO:                    is_mt_s  = 1'b1;
            default:                             is_mul_s = 1'b0;
        endcase
    end

    assign start_s = op_valid & (is_mul_s | is_div_s) & ~busy_q & ~exc_int;
    assign mt_ok_s = op_valid & is_mt_s & ~busy_q & ~exc_int;

    // Operand extension and 2W-bit product
    always_comb begin
        mul_signed_s = (op != OP_MULTU);
        if (mul_signed_s) begin
            mul_a_s = {{WIDTH{D1[WIDTH-1]}}, D1};
            mul_b_s = {{WIDTH{D2[WIDTH-1]}}, D2};
        end else begin
            mul_a_s = {{WIDTH{1'b0}}, D1};
            mul_b_s = {{WIDTH{1'b0}}, D2};
        end
        prod_s = mul_a_s * mul_b_s;
    end

    // Sign-magnitude division; -2^(W-1)/-1 naturally yields quotient -2^(W-1), remainder 0
    always_comb begin
        a_neg_s = (op == OP_DIV) & D1[WIDTH-1];
        b_neg_s = (op == OP_DIV) & D2[WIDTH-1];
        abs_a_s = a_neg_s ? -D1 : D1;
        abs_b_s = b_neg_s ? -D2 : D2;
        uq_s    = abs_a_s / abs_b_s;
        ur_s    = abs_a_s % abs_b_s;
        quot_s  = (a_neg_s ^ b_neg_s) ? -uq_s : uq_s;
        rem_s   = a_neg_s ? -ur_s : ur_s;
    end

    // Result selection; divide-by-zero reproduces current HI/LO
    always_comb begin
        res_hi_s = hi_q;
        res_lo_s = lo_q;
        case (op)
            OP_MULT, OP_MULTU: {res_hi_s, res_lo_s} = prod_s;
            OP_MADD:           {res_hi_s, res_lo_s} = {hi_q, lo_q} + prod_s;
            OP_MSUB:           {res_hi_s, res_lo_s} = {hi_q, lo_q} - prod_s;
            OP_DIV, OP_DIVU: begin
                if (D2 == {WIDTH{1'b0}}) begin
                    res_hi_s = hi_q;
                    res_lo_s = lo_q;
                end else begin
                    res_hi_s = rem_s;
                    res_lo_s = quot_s;
                end
            end
            default: res_hi_s = hi_q;
        endcase
    end

    // Next-state: countdown while busy, otherwise issue or move-to-HI/LO
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        if (busy_q) begin
            cnt_d = cnt_q - ONE;
            if (cnt_q == ONE) begin
                hi_d   = pend_hi_q;
                lo_d   = pend_lo_q;
                busy_d = 1'b0;
            end else begin
                busy_d = 1'b1;
            end
        end else if (start_s) begin
            cnt_d     = is_mul_s ? MUL_N : DIV_N;
            busy_d    = 1'b1;
            pend_hi_d = res_hi_s;
            pend_lo_d = res_lo_s;
        end else if (mt_ok_s) begin
            if (op == OP_MTHI) begin
                hi_d = D1;
            end else begin
                lo_d = D1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            pend_hi_q <= {WIDTH{1'b0}};
            pend_lo_q <= {WIDTH{1'b0}};
            busy_q    <= 1'b0;
            cnt_q     <= {CW{1'b0}};
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
        end
    end

    assign start = start_s;
    assign busy  = busy_q;
    assign HI    = hi_q;
    assign LO    = lo_q;

endmodule

// File: doc/md_iter_unit.md
Name: md_iter_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the E stage of the pipelined MIPS CPU.
- Successor to the fixed 32-bit MD unit. Adds:
  - configurable data width and latencies
  - MADD/MSUB accumulate
  - defined divide-by-zero and signed-overflow results
  - exception cancellation of issue
- Drives start/busy into the hazard unit (stall = start || busy) and HI/LO into the M-stage pipeline register.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_CYCLES, 5, busy cycles for MULT/MULTU/MADD/MSUB (>=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1).

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- op_valid  input  1  E-stage instruction is an MD-class op.
- op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MSUB; 9-15 treated as NONE.
- D1  input  WIDTH  rs operand (forwarded).
- D2  input  WIDTH  rt operand (forwarded).
- exc_int  input  1  exception/interrupt taken this cycle; the E-stage op is flushed.
- start  output  1  combinational issue indicator.
- busy  output  1  registered; operation in flight.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- Clock and reset: one clock clk; reset is synchronous and active-high.
- Reset: HI=0, LO=0, busy=0, counter=0, pending result=0. Reset wins over every other event, including mid-operation; the in-flight op is discarded and HI/LO are zeroed.
- Multi-cycle ops: ops 1-4 and 7-8.
- start = op_valid & multi-cycle op & !busy & !exc_int. Purely combinational; no registered copy.
- Issue edge (start=1):
  - latch D1 and D2
  - compute the result into pending_hi/pending_lo
  - load counter with N (MUL_CYCLES or DIV_CYCLES)
  - set busy=1
- Result computation:
  - MULT/MULTU: {hi,lo} = 2W-bit signed/unsigned product.
  - MADD/MSUB: {HI,LO} ± signed product, modulo 2^(2W). Uses HI/LO as they stand at the issue edge.
  - DIV/DIVU: lo = quotient, hi = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero (D2=0): pending = current HI/LO, so HI/LO end unchanged. busy still runs the full DIV_CYCLES.
  - Signed overflow (D1 = -2^(W-1), D2 = -1): lo = -2^(W-1), hi = 0.
- Busy phase:
  - While busy, the counter decrements each edge.
  - On the edge where the counter goes 1→0: HI/LO ← pending, busy ← 0.
  - Timing: issue in cycle T gives busy=1 in cycles T+1..T+N and new HI/LO visible from cycle T+N+1.
- exc_int:
  - Blocks issue in the same cycle (start=0, no state change).
  - Does not abort an op already busy; that instruction has committed past M.
  - Blocks MTHI/MTLO in the same cycle.
- Requests while busy: any op_valid op (including MTHI/MTLO) is ignored; the hazard unit guarantees a stall. The counter and pending result are unaffected.
- MTHI/MTLO: op_valid & !busy & !exc_int → HI (or LO) ← D1 at the next edge. Single cycle; start=0, busy stays 0.
- NONE or undefined op: no effect.
- HI/LO change only on the completion edge, on an MTHI/MTLO edge, or on reset.

Test Plan:
- Basic multiply: MULT D1=0xFFFFFFFE (-2), D2=3 → start=1 for 1 cycle; busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Unsigned multiply: MULTU D1=0xFFFFFFFF, D2=2 → after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- Signed divide: DIV D1=-7 (0xFFFFFFF9), D2=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide edge cases:
  - DIVU D2=0 with HI=0x11, LO=0x22 → busy for 10 cycles; HI/LO remain 0x11/0x22.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Exceptions and interlocks:
  - MULT with exc_int=1 in the issue cycle → start=0, busy never rises.
  - exc_int asserted during busy → op completes normally.
  - MTLO presented while busy → LO unchanged.
- Accumulate, move and reset:
  - MTHI 0, MTLO 10, then MADD 3×4 → HI=0, LO=22.
  - MSUB 5×5 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - reset asserted in busy cycle 3 → next cycle busy=0, HI=LO=0; no later update occurs.
